// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-port 256x16 RAM between two requesters. Port 0 is the
//   CPU memory port and port 1 is an IO/DMA requester. A request is latched
//   in IDLE, granted for exactly one ACCESS cycle, and a read returns its data
//   in the RDATA cycle that follows. Only one transaction is in flight at a
//   time. When both ports request, the port that did not win last time gets
//   the grant.
//
//   Command encoding: MWRITE=2'b01, MREAD=2'b11, and any other code is a
//   no-op. An address with its MSB set lies outside RAM space: writes there
//   are dropped and reads return zero.
//
//   Handshake: the requester raises rN_req with cmd/addr/wdata stable and
//   holds them until the clock edge that ends its one-cycle rN_gnt pulse.
//   If req is still high in IDLE after that, it is a new request. For a read,
//   rN_rvalid pulses for one cycle in the cycle after rN_gnt, and rN_rdata is
//   valid only in that cycle (it is zero at all other times).
//
// Ports
//   clk, reset            rising-edge clock, asynchronous active-low reset
//   rN_req/cmd/addr/wdata request side of port N (N = 0, 1)
//   rN_gnt, rN_rvalid     one-cycle grant and read-valid pulses
//   rN_rdata              read data, nonzero only during rN_rvalid
//   ram_addr/write/din    RAM control, driven only during ACCESS
//   ram_dout              RAM read data, one cycle of latency after ram_addr
//   dbg_state             current FSM state (0 IDLE, 1 ACCESS, 2 RDATA)
//   r0_count, r1_count    saturating grant counters, present only when
//                         MEM_PORT_ARBITER_STATS_EN is defined
module mem_port_arbiter #(
  parameter int DATA_WIDTH = 16,
  parameter int ADDR_WIDTH = 9
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  r0_req,
  input  logic [1:0]            r0_cmd,
  input  logic [ADDR_WIDTH-1:0] r0_addr,
  input  logic [DATA_WIDTH-1:0] r0_wdata,
  output logic                  r0_gnt,
  output logic                  r0_rvalid,
  output logic [DATA_WIDTH-1:0] r0_rdata,
  input  logic                  r1_req,
  input  logic [1:0]            r1_cmd,
  input  logic [ADDR_WIDTH-1:0] r1_addr,
  input  logic [DATA_WIDTH-1:0] r1_wdata,
  output logic                  r1_gnt,
  output logic                  r1_rvalid,
  output logic [DATA_WIDTH-1:0] r1_rdata,
  output logic [ADDR_WIDTH-2:0] ram_addr,
  output logic                  ram_write,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
`ifdef MEM_PORT_ARBITER_STATS_EN
  output logic [15:0]           r0_count,
  output logic [15:0]           r1_count,
`endif
  output logic [1:0]            dbg_state
);

  localparam logic [1:0] MWRITE = 2'b01;
  localparam logic [1:0] MREAD  = 2'b11;
  localparam int         MSB    = ADDR_WIDTH - 1;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    ACCESS = 2'd1,
    RDATA  = 2'd2
  } state_t;

  state_t state;
  logic   last_winner;  // index of the port granted most recently
  logic   lat_win;      // port owning the current transaction
  logic   lat_msb;      // current transaction targets non-RAM space
  logic   lat_read;     // current transaction is MREAD

  logic                  any_req;
  logic                  win_next;
  logic [1:0]            sel_cmd;
  logic [ADDR_WIDTH-1:0] sel_addr;
  logic [DATA_WIDTH-1:0] sel_wdata;

  // Round-robin choice: a lone requester always wins. On a tie, the port that
  // did not win last time gets the grant.
  always_comb begin
    any_req  = r0_req | r1_req;
    win_next = 1'b0;
    if (r0_req && r1_req) begin
      win_next = ~last_winner;
    end else if (r1_req) begin
      win_next = 1'b1;
    end
    sel_cmd   = win_next ? r1_cmd   : r0_cmd;
    sel_addr  = win_next ? r1_addr  : r0_addr;
    sel_wdata = win_next ? r1_wdata : r0_wdata;
  end

  // All pulse and RAM outputs default to zero every cycle. They are set only
  // on the transition into the state in which they must be high, so each one
  // lasts exactly one cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state       <= IDLE;
      last_winner <= 1'b1;
      lat_win     <= 1'b0;
      lat_msb     <= 1'b0;
      lat_read    <= 1'b0;
      r0_gnt      <= 1'b0;
      r1_gnt      <= 1'b0;
      r0_rvalid   <= 1'b0;
      r1_rvalid   <= 1'b0;
      ram_write   <= 1'b0;
      ram_addr    <= '0;
      ram_din     <= '0;
    end else begin
      r0_gnt    <= 1'b0;
      r1_gnt    <= 1'b0;
      r0_rvalid <= 1'b0;
      r1_rvalid <= 1'b0;
      ram_write <= 1'b0;
      ram_addr  <= '0;
      ram_din   <= '0;
      case (state)
        IDLE: begin
          if (any_req) begin
            state       <= ACCESS;
            lat_win     <= win_next;
            last_winner <= win_next;
            lat_msb     <= sel_addr[MSB];
            lat_read    <= (sel_cmd == MREAD);
            r0_gnt      <= ~win_next;
            r1_gnt      <= win_next;
            ram_addr    <= sel_addr[ADDR_WIDTH-2:0];
            ram_din     <= sel_wdata;
            ram_write   <= (sel_cmd == MWRITE) && !sel_addr[MSB];
          end
        end
        ACCESS: begin
          if (lat_read) begin
            state     <= RDATA;
            r0_rvalid <= ~lat_win;
            r1_rvalid <= lat_win;
          end else begin
            state <= IDLE;
          end
        end
        RDATA:   state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

  // The RAM registers its output, so read data has to pass straight through
  // in RDATA. Registering it here would add a cycle of latency. Reads from
  // non-RAM space return zero.
  always_comb begin
    r0_rdata = '0;
    r1_rdata = '0;
    if (state == RDATA && !lat_msb) begin
      if (lat_win) r1_rdata = ram_dout;
      else         r0_rdata = ram_dout;
    end
  end

  assign dbg_state = state;

`ifdef MEM_PORT_ARBITER_STATS_EN
  // Each counter steps at the same edge that raises its gnt pulse and
  // saturates at 16'hFFFF.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r0_count <= '0;
      r1_count <= '0;
    end else if (state == IDLE && any_req) begin
      if (!win_next && r0_count != 16'hFFFF) r0_count <= r0_count + 16'd1;
      if (win_next && r1_count != 16'hFFFF)  r1_count <= r1_count + 16'd1;
    end
  end
`endif

endmodule
